mips_state_dump: RTL and testbench

Architectural-state readback engine for the MIPS core; the read-side counterpart of register-file and instruction/data-memory preload.
- On a start pulse it stalls the CPU, scans every register-file entry, then every data-memory word, through the existing asynchronous read ports.
- Words are streamed out on a valid/ready interface for a scoreboard or debug link.
- Sits beside TOP, sharing the RF and data-memory read ports through a mux controlled by cpu_stall.

---
 rtl/mips_dbg_pkg.sv | 21 ++
 rtl/dump_out_reg.sv | 43 ++++
 rtl/mips_state_dump.sv | 166 ++++++++++++++++
 tb/tb_mips_state_dump.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS architectural-state dump engine.
// Optional checksum beat is enabled with the DUMP_CHECKSUM_EN macro.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REGS,
        MEM,
        SUM,
        DRAIN
    } dump_state_t;

    localparam logic [1:0] KIND_REG = 2'b00;
    localparam logic [1:0] KIND_MEM = 2'b01;
    localparam logic [1:0] KIND_SUM = 2'b10;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_REG_DEPTH  = 32;
    localparam int DEF_DMEM_DEPTH = 32;

endpackage

// File: rtl/dump_out_reg.sv
// Single-entry valid/ready output register for dump beats; holds its
// payload stable while the sink back-pressures.
module dump_out_reg
    import mips_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_W      = 5
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_kind,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic                  in_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_kind,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last
);

    // A new beat may replace the current one in the same cycle it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_kind  <= KIND_REG;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_kind  <= in_kind;
            out_idx   <= in_idx;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_state_dump.sv
// Architectural-state readback: stalls the CPU and streams every register
// and data-memory word. Define DUMP_CHECKSUM_EN to append a checksum beat.
module mips_state_dump
    import mips_dbg_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_DEPTH      = DEF_REG_DEPTH,
    parameter int Data_MEM_DEPTH = DEF_DMEM_DEPTH,
    localparam int IDX_W = $clog2((REG_DEPTH > Data_MEM_DEPTH) ? REG_DEPTH : Data_MEM_DEPTH),
    localparam int RA_W  = $clog2(REG_DEPTH),
    localparam int DA_W  = $clog2(Data_MEM_DEPTH)
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    output logic                  cpu_stall,
    output logic [RA_W-1:0]       rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [DA_W-1:0]       dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_kind,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  done
);

    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_DEPTH - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(Data_MEM_DEPTH - 1);

    dump_state_t           state;
    logic [IDX_W-1:0]      idx;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic [1:0]            load_kind;
    logic [IDX_W-1:0]      load_idx;
    logic                  load_last;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
`endif

    assign cpu_stall = (state != IDLE);
    assign rf_addr   = (state == REGS) ? idx[RA_W-1:0] : '0;
    assign dmem_addr = (state == MEM)  ? idx[DA_W-1:0] : '0;
    assign load      = (!out_valid || out_ready) &&
                       (state == REGS || state == MEM || state == SUM);

    // Select the payload for the next beat from whichever region is active.
    always_comb begin
        load_data = '0;
        load_kind = KIND_REG;
        load_idx  = idx;
        load_last = 1'b0;
        case (state)
            REGS: load_data = rf_rdata;
            MEM: begin
                load_data = dmem_rdata;
                load_kind = KIND_MEM;
`ifdef DUMP_CHECKSUM_EN
                load_last = 1'b0;
`else
                load_last = (idx == MEM_LAST);
`endif
            end
`ifdef DUMP_CHECKSUM_EN
            SUM: begin
                load_data = sum;
                load_kind = KIND_SUM;
                load_idx  = '0;
                load_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Scan sequencer: idx advances only when a beat is actually loaded, so
    // back-pressure can never skip or repeat a word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state <= REGS;
                        idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                        sum   <= '0;
`endif
                    end
                end
                REGS: begin
                    if (load) begin
`ifdef DUMP_CHECKSUM_EN
                        sum <= sum + rf_rdata;
`endif
                        if (idx == REG_LAST) begin
                            idx   <= '0;
                            state <= MEM;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (load) begin
`ifdef DUMP_CHECKSUM_EN
                        sum <= sum + dmem_rdata;
`endif
                        if (idx == MEM_LAST) begin
                            idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                            state <= SUM;
`else
                            state <= DRAIN;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                SUM: begin
                    if (load) state <= DRAIN;
                end
`endif
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dump_out_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W)
    ) u_out (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (load),
        .in_data  (load_data),
        .in_kind  (load_kind),
        .in_idx   (load_idx),
        .in_last  (load_last),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_kind (out_kind),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

endmodule

// File: tb/tb_mips_state_dump.sv
// Self-checking bench for mips_state_dump: timing table, back-pressure,
// restart/reset corner cases and randomized scoreboard runs.
module tb_mips_state_dump;
    import mips_dbg_pkg::*;

    localparam int LOG_LEN = 80;
`ifdef DUMP_CHECKSUM_EN
    localparam int TOTAL_BEATS = 65;
    localparam int EXP_DONE    = 67;
`else
    localparam int TOTAL_BEATS = 64;
    localparam int EXP_DONE    = 66;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  kind;
        int          idx;
        logic        last;
    } beat_t;

    typedef struct {
        int          off;
        logic        stall;
        logic        valid;
        logic        done;
        logic [1:0]  kind;
        int          idx;
        logic        last;
        logic [31:0] data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cpu_stall;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic [4:0]  dmem_addr;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_kind;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        done;

    logic [31:0] rf   [32];
    logic [31:0] dmem [32];

    beat_t exp_q[$];
    vec_t  vecs[$];

    logic        stall_log [LOG_LEN];
    logic        valid_log [LOG_LEN];
    logic        done_log  [LOG_LEN];
    logic [39:0] beat_log  [LOG_LEN];

    int checks_total;
    int checks_passed;
    int run_beats;
    int run_done_cycle;
    int run_done_count;
    int run_last_hs;

    assign rf_rdata   = rf[rf_addr];
    assign dmem_rdata = dmem[dmem_addr];

    mips_state_dump dut (
        .CLK       (clk),
        .RST       (rst_n),
        .start     (start),
        .cpu_stall (cpu_stall),
        .rf_addr   (rf_addr),
        .rf_rdata  (rf_rdata),
        .dmem_addr (dmem_addr),
        .dmem_rdata(dmem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_kind  (out_kind),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks_total++;
        if (act === expv) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [39:0] pack_beat(logic [31:0] d, logic [1:0] k, int i, logic l);
        return {d, k, 5'(i), l};
    endfunction

    function automatic void add_vec(int off, logic stall, logic valid, logic dn,
                                    logic [1:0] kind, int idx, logic last, logic [31:0] data);
        vec_t v;
        v.off = off; v.stall = stall; v.valid = valid; v.done = dn;
        v.kind = kind; v.idx = idx; v.last = last; v.data = data;
        vecs.push_back(v);
    endfunction

    function automatic void preload_directed();
        for (int i = 0; i < 32; i++) begin
            rf[i]   = 32'(i);
            dmem[i] = 32'h100 + 32'(i);
        end
    endfunction

    function automatic void preload_random();
        for (int i = 0; i < 32; i++) begin
            rf[i]   = $urandom;
            dmem[i] = $urandom;
        end
    endfunction

    function automatic logic [52:0] all_outputs();
        return {out_valid, out_data, out_kind, out_idx, out_last, done, cpu_stall, rf_addr, dmem_addr};
    endfunction

    // mode: 0 ready always high, 1 toggling, 2 random, 3 hold reg beat 5 for 3 cycles
    task automatic applyStimulus(input int mode, input int restart_beat, input int reset_mem_idx);
        beat_t       b;
        logic [31:0] sum;
        int          c;
        int          hold;
        bit          restarted;
        bit          prev_hold;
        bit          finished;
        logic [39:0] held;

        exp_q.delete();
        sum = 0;
        for (int i = 0; i < 32; i++) begin
            b.data = rf[i]; b.kind = KIND_REG; b.idx = i; b.last = 1'b0;
            exp_q.push_back(b);
            sum += rf[i];
        end
        for (int j = 0; j < 32; j++) begin
            b.data = dmem[j]; b.kind = KIND_MEM; b.idx = j;
`ifdef DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (j == 31);
`endif
            exp_q.push_back(b);
            sum += dmem[j];
        end
`ifdef DUMP_CHECKSUM_EN
        b.data = sum; b.kind = KIND_SUM; b.idx = 0; b.last = 1'b1;
        exp_q.push_back(b);
`endif

        run_beats = 0; run_done_cycle = -1; run_done_count = 0; run_last_hs = -1;
        hold = 0; restarted = 0; prev_hold = 0; finished = 0; held = '0;

        @(negedge clk);
        c = 0;
        start = 1'b1;
        out_ready = 1'b1;
        stall_log[0] = cpu_stall; valid_log[0] = out_valid; done_log[0] = done;
        beat_log[0] = pack_beat(out_data, out_kind, int'(out_idx), out_last);

        while (!finished) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (restart_beat >= 0 && !restarted && run_beats == restart_beat) begin
                start = 1'b1;
                restarted = 1;
            end

            if (reset_mem_idx >= 0 && out_valid && out_kind == KIND_MEM && int'(out_idx) == reset_mem_idx) begin
                rst_n = 1'b0;
                #1;
                checkOutput("async reset mid-dump", 64'(all_outputs()), 64'd0);
                @(negedge clk);
                checkOutput("reset held, no done", 64'(all_outputs()), 64'd0);
                rst_n = 1'b1;
                return;
            end

            case (mode)
                1: out_ready = (c % 2 == 0);
                2: out_ready = ($urandom_range(0, 3) != 0);
                3: begin
                    if (out_valid && out_kind == KIND_REG && out_idx == 5'd5 && hold < 3) begin
                        out_ready = 1'b0;
                        hold++;
                        checkOutput($sformatf("hold reg5 beat %0d", hold),
                                    {out_data, 27'(out_idx)}, {32'd5, 27'd5});
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase

            if (c < LOG_LEN) begin
                stall_log[c] = cpu_stall; valid_log[c] = out_valid; done_log[c] = done;
                beat_log[c] = pack_beat(out_data, out_kind, int'(out_idx), out_last);
            end

            if (prev_hold)
                checkOutput("stable under backpressure",
                            {23'd0, out_valid, pack_beat(out_data, out_kind, int'(out_idx), out_last)},
                            {23'd0, 1'b1, held});

            if (run_done_count > 0 && c == run_done_cycle + 1) begin
                checkOutput("no beat after done", 64'(out_valid), 64'd0);
                finished = 1;
            end

            if (done) begin
                run_done_count++;
                if (run_done_count == 1) run_done_cycle = c;
            end

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected extra beat", 64'd1, 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    if (pack_beat(out_data, out_kind, int'(out_idx), out_last) !==
                        pack_beat(b.data, b.kind, b.idx, b.last))
                        checkOutput($sformatf("beat %0d", run_beats),
                                    64'(pack_beat(out_data, out_kind, int'(out_idx), out_last)),
                                    64'(pack_beat(b.data, b.kind, b.idx, b.last)));
                    else
                        checkOutput($sformatf("beat %0d", run_beats), 64'd1, 64'd1 & 64'(out_valid));
                end
                run_beats++;
                run_last_hs = c;
            end

            prev_hold = out_valid && !out_ready;
            held = pack_beat(out_data, out_kind, int'(out_idx), out_last);

            if (c > 600 && !finished) begin
                checkOutput("done timeout", 64'(run_done_count), 64'd1);
                finished = 1;
            end
        end

        checkOutput("beat count", 64'(run_beats), 64'(TOTAL_BEATS));
        checkOutput("done after last handshake", 64'(run_done_cycle), 64'(run_last_hs + 1));
        if (mode == 3) checkOutput("hold cycles applied", 64'(hold), 64'd3);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("idle after done", {61'd0, cpu_stall, done, out_valid}, 64'd0);
        end
    endtask

    initial begin
        checks_total = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        preload_directed();

        #12;
        checkOutput("reset outputs", 64'(all_outputs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        add_vec(0,  1'b0, 1'b0, 1'b0, KIND_REG, 0,  1'b0, 32'h0);
        add_vec(1,  1'b1, 1'b0, 1'b0, KIND_REG, 0,  1'b0, 32'h0);
        add_vec(2,  1'b1, 1'b1, 1'b0, KIND_REG, 0,  1'b0, 32'h0);
        add_vec(7,  1'b1, 1'b1, 1'b0, KIND_REG, 5,  1'b0, 32'h5);
        add_vec(33, 1'b1, 1'b1, 1'b0, KIND_REG, 31, 1'b0, 32'd31);
        add_vec(34, 1'b1, 1'b1, 1'b0, KIND_MEM, 0,  1'b0, 32'h100);
`ifdef DUMP_CHECKSUM_EN
        add_vec(65, 1'b1, 1'b1, 1'b0, KIND_MEM, 31, 1'b0, 32'h11F);
        add_vec(66, 1'b1, 1'b1, 1'b0, KIND_SUM, 0,  1'b1, 32'h23E0);
        add_vec(67, 1'b0, 1'b0, 1'b1, KIND_REG, 0,  1'b0, 32'h0);
        add_vec(68, 1'b0, 1'b0, 1'b0, KIND_REG, 0,  1'b0, 32'h0);
`else
        add_vec(65, 1'b1, 1'b1, 1'b0, KIND_MEM, 31, 1'b1, 32'h11F);
        add_vec(66, 1'b0, 1'b0, 1'b1, KIND_REG, 0,  1'b0, 32'h0);
        add_vec(67, 1'b0, 1'b0, 1'b0, KIND_REG, 0,  1'b0, 32'h0);
`endif

        $display("[TB] directed dump, ready held high");
        applyStimulus(0, -1, -1);
        checkOutput("done cycle", 64'(run_done_cycle), 64'(EXP_DONE));
        foreach (vecs[i]) begin
            checkOutput($sformatf("t%0d ctl", vecs[i].off),
                        {61'd0, stall_log[vecs[i].off], valid_log[vecs[i].off], done_log[vecs[i].off]},
                        {61'd0, vecs[i].stall, vecs[i].valid, vecs[i].done});
            if (vecs[i].valid)
                checkOutput($sformatf("t%0d beat", vecs[i].off), 64'(beat_log[vecs[i].off]),
                            64'(pack_beat(vecs[i].data, vecs[i].kind, vecs[i].idx, vecs[i].last)));
        end

        $display("[TB] back-pressure on reg beat 5");
        applyStimulus(3, -1, -1);

        $display("[TB] start re-pulsed at beat 10");
        applyStimulus(0, 10, -1);

        $display("[TB] reset during mem beat 7, then full dump");
        applyStimulus(0, -1, 7);
        @(negedge clk);
        applyStimulus(0, -1, -1);

        $display("[TB] ready toggling every cycle");
        applyStimulus(1, -1, -1);

        for (int r = 0; r < 3; r++) begin
            $display("[TB] random run %0d", r);
            preload_random();
            applyStimulus(2, -1, -1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
